// File: rtl/result_writeback.sv
// Result write-back buffer: DEPTH-entry {addr, data} FIFO between an accelerator result port and memory,
// with a completion FSM. Optional address-sequence checking is enabled by defining RESULT_WB_ADDR_CHECK_EN.
module result_writeback #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 23,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        comp_enb,
  input  logic                        in_wr_enb,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_done,
  output logic                        out_valid,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic                        addr_err,
  output logic                        wb_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  state_t                r_state;
  state_t                w_state_next;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_pop  = out_valid & out_ready;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_push = in_wr_enb & (~w_full | w_pop);
  assign w_drop = in_wr_enb & w_full & ~w_pop;

  assign out_valid = (r_level != '0);
  assign out_addr  = r_mem_addr[r_rd_ptr];
  assign out_data  = r_mem_data[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign wb_done   = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= in_addr;
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge comp_enb) begin
    if (comp_enb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge comp_enb) begin
    if (comp_enb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_done) begin
          w_state_next = S_FLUSH;
        end else if (w_push) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (in_done) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((r_level == '0) && !w_push) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_push) begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef RESULT_WB_ADDR_CHECK_EN
  logic [ADDR_WIDTH-1:0] r_prev_addr;
  logic                  r_prev_vld;
  logic                  r_addr_err;

  // Only accepted pushes advance the expected address; the first one after reset just seeds it.
  always_ff @(posedge clk or posedge comp_enb) begin
    if (comp_enb) begin
      r_prev_addr <= '0;
      r_prev_vld  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else if (w_push) begin
      if (r_prev_vld && (in_addr != r_prev_addr + 1'b1)) begin
        r_addr_err <= 1'b1;
      end
      r_prev_addr <= in_addr;
      r_prev_vld  <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_writeback.sv
// Directed scoreboard bench for result_writeback (DEPTH=8): stimulus queues expected pops,
// a negedge monitor compares every accepted head entry.
module tb_result_writeback;

  localparam int DW = 64;
  localparam int AW = 23;
`ifdef RESULT_WB_ADDR_CHECK_EN
  localparam logic ADDR_CHK = 1'b1;
`else
  localparam logic ADDR_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          comp_enb;
  logic          in_wr_enb;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_done;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [3:0]    level;
  logic          overflow;
  logic          addr_err;
  logic          wb_done;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW-1:0] sb [$];

  result_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(8)) dut (
    .clk       (clk),
    .comp_enb  (comp_enb),
    .in_wr_enb (in_wr_enb),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_done   (in_done),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .addr_err  (addr_err),
    .wb_done   (wb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    in_wr_enb = 1'b1;
    in_addr   = a;
    in_data   = d;
    if (accept) sb.push_back({a, d});
    tick();
    in_wr_enb = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 4 && !wb_done; i++) tick();
    chk(nm, 64'(wb_done), 64'd1);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready at the falling edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got addr 0x%0h data 0x%0h expected no entry", out_addr, out_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = sb.pop_front();
        chk("pop_addr", 64'(out_addr), 64'(e[AW+DW-1:DW]));
        chk("pop_data", out_data, e[DW-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    comp_enb  = 1'b1;
    in_wr_enb = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_done   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    comp_enb = 1'b0;
    tick();

    // Single word, latency 1, popped immediately.
    out_ready = 1'b1;
    push(23'h10, 64'hA, 1'b1);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_addr", 64'(out_addr), 64'h10);
    chk("one_data", out_data, 64'hA);
    chk("one_level", 64'(level), 64'd1);
    tick();
    chk("one_level_after_pop", 64'(level), 64'd0);
    chk("one_valid_after_pop", 64'(out_valid), 64'd0);

    // Fill, push+pop at full, overflow on a dropped write, then drain in order.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(23'(16 + i), 64'(i), 1'b1);
    chk("full_level", 64'(level), 64'd8);
    chk("full_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    push(23'h19, 64'd9, 1'b1);
    chk("pushpop_level", 64'(level), 64'd8);
    chk("pushpop_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    push(23'h1A, 64'hDEAD, 1'b0);
    chk("drop_level", 64'(level), 64'd8);
    chk("drop_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_level", 64'(level), 64'd0);
    chk("seq_addr_err", 64'(addr_err), 64'd0);

    // Flush with three buffered entries.
    out_ready = 1'b0;
    push(23'h1A, 64'h1A1, 1'b1);
    push(23'h1B, 64'h1B1, 1'b1);
    push(23'h1C, 64'h1C1, 1'b1);
    chk("flush_level", 64'(level), 64'd3);
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    chk("flush_no_done", 64'(wb_done), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    wait_done("flush_wb_done");
    chk("flush_level_zero", 64'(level), 64'd0);
    push(23'h1D, 64'h1D1, 1'b1);
    chk("done_cleared", 64'(wb_done), 64'd0);
    chk("done_push_level", 64'(level), 64'd1);
    tick();

    // Address sequence 5, 6, 8 after a fresh reset.
    comp_enb = 1'b1;
    tick();
    comp_enb  = 1'b0;
    out_ready = 1'b0;
    push(23'd5, 64'h55, 1'b1);
    push(23'd6, 64'h66, 1'b1);
    chk("addr_err_ok", 64'(addr_err), 64'd0);
    push(23'd8, 64'h88, 1'b1);
    chk("addr_err_gap", 64'(addr_err), 64'(ADDR_CHK));
    push(23'd9, 64'h99, 1'b1);
    push(23'd10, 64'hAA, 1'b1);
    chk("burst_level", 64'(level), 64'd5);

    // Asynchronous reset mid-burst, observed before any clock edge.
    comp_enb = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_addr_err", 64'(addr_err), 64'd0);
    sb.delete();
    tick();
    comp_enb = 1'b0;

    // in_done straight from IDLE.
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    wait_done("idle_flush_wb_done");

    out_ready = 1'b1;
    push(23'h40, 64'h123, 1'b1);
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_wb_done", 64'(wb_done), 64'd0);
    tick();
    chk("post_level", 64'(level), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, result word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 23, result address width.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port comp_enb  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_wr_enb  input  1  write strobe from the accelerator result port.
REQ-007 SHALL have port in_addr  input  ADDR_WIDTH  result address, qualified by in_wr_enb.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  result data, qualified by in_wr_enb.
REQ-009 SHALL have port in_done  input  1  accelerator done; sampled each cycle.
REQ-010 SHALL have port out_valid  output  1  head entry available to memory.
REQ-011 SHALL have port out_addr  output  ADDR_WIDTH  head entry address.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  head entry data.
REQ-013 SHALL have port out_ready  input  1  memory accepts head entry.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  current entry count.
REQ-015 SHALL have port overflow  output  1  sticky; a write was dropped.
REQ-016 SHALL have port addr_err  output  1  sticky address-sequence error (see Configuration).
REQ-017 SHALL have port wb_done  output  1  all results written after in_done.

Function
REQ-018 SHALL implement a DEPTH-entry FIFO of {addr, data} with read and write pointers wrapping modulo DEPTH.
REQ-019 SHALL push when in_wr_enb=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-020 SHALL pop when out_valid=1 and out_ready=1; out_addr/out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_valid=1 exactly when level!=0; out_addr/out_data are a combinational read of the head entry.
REQ-022 SHALL make a word pushed at edge N visible at the outputs after edge N (latency 1 cycle); no bypass while empty.
REQ-023 SHALL, when in_wr_enb=1 and level=DEPTH and no pop occurs, drop the write, leave the FIFO unchanged, and set overflow=1 until reset.
REQ-024 SHALL update level by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 SHALL run an FSM with states IDLE, RUN, FLUSH, DONE.
REQ-026 SHALL transition IDLE->RUN on the first push and IDLE->FLUSH when in_done=1.
REQ-027 SHALL transition RUN->FLUSH when in_done=1; a push in the same cycle is still accepted.
REQ-028 SHALL transition FLUSH->DONE when level=0 and no push occurs in that cycle; pushes in FLUSH are accepted.
REQ-029 SHALL drive wb_done=1 only in DONE, and SHALL transition DONE->RUN on a push, clearing wb_done.
REQ-030 SHALL ignore in_done outside IDLE and RUN.

Reset
REQ-031 SHALL, while comp_enb=1, asynchronously force state=IDLE, pointers=0, level=0, out_valid=0, overflow=0, addr_err=0, wb_done=0; FIFO contents are don't-care.
REQ-032 SHALL discard all buffered entries on reset mid-operation; no pop occurs while comp_enb=1.

Configuration
REQ-033 SHALL, with RESULT_WB_ADDR_CHECK_EN defined, set addr_err=1 (sticky) when an accepted push has in_addr != previous accepted in_addr + 1 modulo 2^ADDR_WIDTH; the first push after reset is exempt.
REQ-034 SHALL, without RESULT_WB_ADDR_CHECK_EN, tie addr_err to 0 and omit the address-tracking register.

Verification (DEPTH=8)
REQ-035 SHALL cover: reset, then push addr 0x10/data 0xA at out_ready=1 -> next cycle out_valid=1, out_addr=0x10, out_data=0xA; popped; level back to 0.
REQ-036 SHALL cover: out_ready=0, 9 consecutive pushes -> level=8, 9th dropped, overflow=1; then drain -> entries 1..8 emerge in order.
REQ-037 SHALL cover: level=8, push and pop in the same cycle -> level stays 8, overflow stays 0.
REQ-038 SHALL cover: 3 entries buffered, in_done pulse, out_ready=1 -> state FLUSH, wb_done=1 in the cycle after the last pop; a later push clears wb_done.
REQ-039 SHALL cover: with RESULT_WB_ADDR_CHECK_EN, pushes to addresses 5, 6, 8 -> addr_err=1 after the third push; without the macro, addr_err stays 0.
REQ-040 SHALL cover: comp_enb asserted mid-burst with level=5 -> out_valid=0 and level=0 immediately, without waiting for a clock edge.
